// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if -- bus bundle between the instruction-memory arbiter and
// its three neighbours: the fetch unit, the program loader and the
// single-port memory.
//   fetch  : f_req/f_addr in, f_gnt/f_valid/f_data/f_err out
//   loader : l_req/l_we/l_addr/l_wdata/l_lock in, l_gnt/l_valid/l_rdata/l_err out
//   memory : mem_we/mem_addr/mem_din out, mem_dout in
//   status : locked out (loader owns the memory)
// The slave modport is the arbiter's view; master is the view of whatever
// drives requests and models the memory.
interface imem_arbiter_if #(
    parameter int size = 32
);
    logic            f_req;
    logic [size-1:0] f_addr;
    logic            f_gnt;
    logic            f_valid;
    logic [size-1:0] f_data;
    logic            f_err;

    logic            l_req;
    logic            l_we;
    logic [size-1:0] l_addr;
    logic [size-1:0] l_wdata;
    logic            l_lock;
    logic            l_gnt;
    logic            l_valid;
    logic [size-1:0] l_rdata;
    logic            l_err;

    logic            mem_we;
    logic [size-1:0] mem_addr;
    logic [size-1:0] mem_din;
    logic [size-1:0] mem_dout;

    logic            locked;

    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_valid, f_data, f_err,
        input  l_req, l_we, l_addr, l_wdata, l_lock,
        output l_gnt, l_valid, l_rdata, l_err,
        output mem_we, mem_addr, mem_din,
        input  mem_dout,
        output locked
    );

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_valid, f_data, f_err,
        output l_req, l_we, l_addr, l_wdata, l_lock,
        input  l_gnt, l_valid, l_rdata, l_err,
        input  mem_we, mem_addr, mem_din,
        output mem_dout,
        input  locked
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter -- shares one single-port instruction memory between the
// fetch unit and the program loader.
//   clka : single clock, all state changes on its rising edge
//   rst  : synchronous, active-high reset
//   bus  : imem_arbiter_if.slave (fetch, loader, memory and locked signals)
// Grants are combinational. A request granted in cycle T drives the memory
// from registers in T+1, the memory output is captured at the end of T+1 and
// the requester's valid pulses in T+2. In RUN the two requesters share the
// memory round-robin; a loader holding l_lock moves the block to LOAD
// (loader only), and on release it passes through DRAIN until the pipeline
// is empty so that later fetches see every word the loader wrote.
module imem_arbiter #(
    parameter int size    = 32,
    parameter int MemSize = 32
) (
    input  logic              clka,
    input  logic              rst,
    imem_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } mode_t;

    localparam logic [size-1:0] MEM_LIMIT = size'(MemSize);

    mode_t           state_r;
    mode_t           state_s;
    logic            last_l_r;     // 1: loader won last, so fetch has priority
    logic            f_gnt_s;
    logic            l_gnt_s;
    logic            f_in_range_s;
    logic            l_in_range_s;
    logic            pipe_empty_s;

    // stage 1: the operation currently presented to the memory
    logic            s1_valid_r;
    logic            s1_is_l_r;
    logic            s1_we_r;
    logic            s1_err_r;
    logic            mem_we_r;
    logic [size-1:0] mem_addr_r;
    logic [size-1:0] mem_din_r;

    // stage 2: returned results
    logic            f_valid_r;
    logic            f_err_r;
    logic [size-1:0] f_data_r;
    logic            l_valid_r;
    logic            l_err_r;
    logic [size-1:0] l_rdata_r;

    assign f_in_range_s = (bus.f_addr < MEM_LIMIT);
    assign l_in_range_s = (bus.l_addr < MEM_LIMIT);
    assign pipe_empty_s = !s1_valid_r && !f_valid_r && !l_valid_r;

    // Grant decision from the current mode, the requests and the pointer.
    always_comb begin
        f_gnt_s = 1'b0;
        l_gnt_s = 1'b0;
        if (rst) begin
            f_gnt_s = 1'b0;
            l_gnt_s = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    // l_lock already shuts fetch out in the cycle it is seen
                    if (bus.l_lock) begin
                        l_gnt_s = bus.l_req;
                    end else if (bus.f_req && bus.l_req) begin
                        if (last_l_r) begin
                            f_gnt_s = 1'b1;
                        end else begin
                            l_gnt_s = 1'b1;
                        end
                    end else begin
                        f_gnt_s = bus.f_req;
                        l_gnt_s = bus.l_req;
                    end
                end
                LOAD:    l_gnt_s = bus.l_req;
                DRAIN:   l_gnt_s = 1'b0;
                default: l_gnt_s = 1'b0;
            endcase
        end
    end

    // Mode transitions.
    always_comb begin
        state_s = state_r;
        case (state_r)
            RUN: begin
                if (bus.l_lock) begin
                    state_s = LOAD;
                end else begin
                    state_s = RUN;
                end
            end
            LOAD: begin
                if (!bus.l_lock) begin
                    state_s = DRAIN;
                end else begin
                    state_s = LOAD;
                end
            end
            DRAIN: begin
                if (bus.l_lock) begin
                    state_s = LOAD;
                end else if (pipe_empty_s) begin
                    state_s = RUN;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: state_s = RUN;
        endcase
    end

    // Mode register and round-robin pointer.
    always_ff @(posedge clka) begin
        if (rst) begin
            state_r  <= RUN;
            last_l_r <= 1'b1;
        end else begin
            state_r <= state_s;
            if (l_gnt_s) begin
                last_l_r <= 1'b1;
            end else if (f_gnt_s) begin
                last_l_r <= 1'b0;
            end else begin
                last_l_r <= last_l_r;
            end
        end
    end

    // Stage 1: register the granted operation onto the memory port.
    always_ff @(posedge clka) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_is_l_r  <= 1'b0;
            s1_we_r    <= 1'b0;
            s1_err_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= {size{1'b0}};
            mem_din_r  <= {size{1'b0}};
        end else begin
            s1_valid_r <= f_gnt_s || l_gnt_s;
            s1_is_l_r  <= l_gnt_s;
            s1_we_r    <= l_gnt_s && bus.l_we;
            s1_err_r   <= l_gnt_s ? !l_in_range_s : !f_in_range_s;
            // out-of-range writes never reach the memory
            mem_we_r   <= l_gnt_s && bus.l_we && l_in_range_s;
            if (l_gnt_s) begin
                mem_addr_r <= bus.l_addr;
                mem_din_r  <= bus.l_wdata;
            end else if (f_gnt_s) begin
                mem_addr_r <= bus.f_addr;
                mem_din_r  <= mem_din_r;
            end else begin
                mem_addr_r <= mem_addr_r;
                mem_din_r  <= mem_din_r;
            end
        end
    end

    // Stage 2: capture memory output and pulse the owner's valid.
    always_ff @(posedge clka) begin
        if (rst) begin
            f_valid_r <= 1'b0;
            f_err_r   <= 1'b0;
            f_data_r  <= {size{1'b0}};
            l_valid_r <= 1'b0;
            l_err_r   <= 1'b0;
            l_rdata_r <= {size{1'b0}};
        end else begin
            f_valid_r <= s1_valid_r && !s1_is_l_r;
            f_err_r   <= s1_valid_r && !s1_is_l_r && s1_err_r;
            l_valid_r <= s1_valid_r && s1_is_l_r;
            l_err_r   <= s1_valid_r && s1_is_l_r && s1_err_r;
            if (s1_valid_r && !s1_is_l_r) begin
                f_data_r <= s1_err_r ? {size{1'b0}} : bus.mem_dout;
            end else begin
                f_data_r <= f_data_r;
            end
            // write acknowledges leave the loader read data untouched
            if (s1_valid_r && s1_is_l_r && !s1_we_r) begin
                l_rdata_r <= s1_err_r ? {size{1'b0}} : bus.mem_dout;
            end else begin
                l_rdata_r <= l_rdata_r;
            end
        end
    end

    // Pulses and mode flag are forced low for the whole reset cycle, not
    // only after the first reset edge.
    assign bus.f_gnt    = f_gnt_s;
    assign bus.l_gnt    = l_gnt_s;
    assign bus.f_valid  = f_valid_r && !rst;
    assign bus.f_err    = f_err_r && !rst;
    assign bus.f_data   = f_data_r;
    assign bus.l_valid  = l_valid_r && !rst;
    assign bus.l_err    = l_err_r && !rst;
    assign bus.l_rdata  = l_rdata_r;
    assign bus.mem_we   = mem_we_r && !rst;
    assign bus.mem_addr = mem_addr_r;
    assign bus.mem_din  = mem_din_r;
    assign bus.locked   = (state_r != RUN) && !rst;
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- size, 32, data and address width in bits.
- MemSize, 32, number of valid words; legal addresses are 0..MemSize-1.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clka, in, 1, the single clock; all state changes on its rising edge.
- rst, in, 1, reset; synchronous, active-high.
- f_req, in, 1, fetch request; held until granted.
- f_addr, in, size, fetch word address; held with f_req.
- f_gnt, out, 1, fetch request accepted this cycle.
- f_valid, out, 1, one-cycle pulse: fetch data returned.
- f_data, out, size, fetch read data.
- f_err, out, 1, qualifies f_valid: address out of range.
- l_req, in, 1, loader request; held until granted.
- l_we, in, 1, loader write (1) or read (0).
- l_addr, in, size, loader word address.
- l_wdata, in, size, loader write data.
- l_lock, in, 1, loader requests exclusive access for a program load.
- l_gnt, out, 1, loader request accepted this cycle.
- l_valid, out, 1, one-cycle pulse: read data returned or write acknowledged.
- l_rdata, out, size, loader read data.
- l_err, out, 1, qualifies l_valid: address out of range.
- mem_we, out, 1, drives the memory wea input.
- mem_addr, out, size, drives the memory addra input.
- mem_din, out, size, drives the memory dina input.
- mem_dout, in, size, douta from the memory.
- locked, out, 1, high while the block is in state LOAD or DRAIN.

Function
REQ-003 Grant: f_gnt and l_gnt SHALL be combinational from the requests and the current state, at most one high per cycle. A request is accepted in the cycle its gnt is high.
REQ-004 In state RUN, a lone request SHALL be granted immediately.
REQ-005 In state RUN, simultaneous requests SHALL be arbitrated round-robin on a 1-bit last-winner pointer. The pointer updates on every grant. After reset the pointer favours fetch.
REQ-006 Cycle timing for a request granted in cycle T:
- mem_addr, mem_we and mem_din SHALL be registered and drive the memory in T+1.
- mem_dout SHALL be sampled at the end of T+1.
- The requester's valid SHALL pulse in T+2 with its data registered.
- Throughput SHALL be one grant per cycle, fully pipelined.
REQ-007 mem_we SHALL be 1 only for a granted, in-range loader write. In every other cycle mem_we SHALL be 0.
REQ-008 Out-of-range access (addr >= MemSize), read or write:
- No memory write SHALL occur.
- Returned data SHALL be 0.
- The err bit SHALL be 1 alongside valid.
REQ-009 A write SHALL produce l_valid in T+2 with l_err as defined and l_rdata unchanged.
REQ-010 Outputs f_data and l_rdata SHALL hold their last value between valid pulses. f_err and l_err SHALL be 0 whenever their valid is 0.
REQ-011 The mode FSM SHALL have states RUN, LOAD and DRAIN, with these transitions:
- RUN -> LOAD when l_lock = 1. In-flight fetches complete normally.
- LOAD: f_gnt = 0; a loader request SHALL be granted every cycle it is present. LOAD -> DRAIN when l_lock = 0.
- DRAIN: no grants; SHALL stay until both pipeline stages are empty (no operation in T+1 or T+2), then -> RUN.
- If l_lock rises again during DRAIN, the FSM SHALL go to LOAD.
REQ-012 In the cycle RUN -> LOAD is taken, l_lock SHALL already block f_gnt, so fetch never wins that cycle.
REQ-013 Fetch reads issued after DRAIN SHALL observe all loader writes made during LOAD.
REQ-014 locked SHALL be registered-state-derived, high in LOAD and DRAIN.

Reset
REQ-015 When rst = 1 at a clock edge, the block SHALL enter state RUN with the pointer favouring fetch and both pipeline stages cleared. In-flight operations SHALL be discarded with no valid pulse.
REQ-016 While rst = 1, the grants, valids, errs, mem_we and locked SHALL all be 0. f_data, l_rdata, mem_addr and mem_din SHALL reset to 0.
REQ-017 The first grant SHALL be possible in the cycle after rst falls.

Verification
REQ-018 A bench SHALL cover the following directed scenarios:
- Lone fetch: f_req with f_addr = 5 in cycle T, memory holds 5 at word 5 -> f_gnt in T, mem_addr = 5 in T+1, f_valid = 1 with f_data = 5 in T+2.
- Contention: f_req and l_req (read, addr 3) held together for 4 cycles after reset -> grants alternate f, l, f, l; valids alternate correspondingly two cycles later.
- Lock sequence: l_lock = 1, write 0xDEADBEEF to addr 7, l_lock = 0, then fetch addr 7 -> f_gnt stays 0 during LOAD and DRAIN; the fetch returns 0xDEADBEEF.
- Out-of-range: loader write to addr 40 -> mem_we stays 0; l_valid = 1 with l_err = 1 in T+2; a following read of addr 40 returns 0 with l_err = 1.
- Reset mid-operation: assert rst in T+1 after a fetch grant -> no f_valid in T+2; all outputs 0; the next request is granted immediately after rst falls.
- Back-to-back fetches to addrs 1, 2, 3 in consecutive cycles -> f_valid high for 3 consecutive cycles with data 1, 2, 3.
